// File: rtl/tetris_pkg.sv
// Playfield geometry, FSM encoding and score limit shared by the line-clear path.
package tetris_pkg;
  localparam int MAP_W     = 8;
  localparam int MAP_H     = 16;
  localparam int MAP_BITS  = MAP_W * MAP_H;
  localparam int MAX_LINES = 99;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [6:0] row_base(input logic [3:0] y);
    return 7'(y) * 7'(MAP_W);
  endfunction
endpackage

// File: rtl/line_clear_if.sv
// Lock-event request and cleaned-map response bundle between placement and scoring.
interface line_clear_if;
  import tetris_pkg::*;

  logic                start;
  logic [MAP_BITS-1:0] map_in;
  logic                busy;
  logic                done;
  logic [MAP_BITS-1:0] map_out;
  logic [4:0]          lines_cleared;
  logic [9:0]          lines_total;
  logic                top_out;

  modport master (output start, map_in,
                  input  busy, done, map_out, lines_cleared, lines_total, top_out);
  modport slave  (input  start, map_in,
                  output busy, done, map_out, lines_cleared, lines_total, top_out);
endinterface

// File: rtl/line_clear_row_collapse.sv
// Removes row y: rows 0..y-1 shift down one, row 0 becomes empty, rows below y untouched.
module row_collapse
  import tetris_pkg::*;
(
  input  logic [MAP_BITS-1:0] i_map,
  input  logic [3:0]          i_y,
  output logic [MAP_BITS-1:0] o_map
);
  for (genvar r = 0; r < MAP_H; r++) begin : g_row
    if (r == 0) begin : g_top
      assign o_map[0 +: MAP_W] = '0;
    end else begin : g_body
      assign o_map[r*MAP_W +: MAP_W] = (4'(r) <= i_y) ? i_map[(r-1)*MAP_W +: MAP_W]
                                                      : i_map[r*MAP_W +: MAP_W];
    end
  end
endmodule

// File: rtl/line_clear.sv
// Bottom-up full-row removal, one row examined per clock; results publish on a single done cycle.
module line_clear
  import tetris_pkg::*;
#(
  parameter int MAXL = MAX_LINES
) (
  input  logic         CLK,
  input  logic         reset,
  line_clear_if.slave  bus
);
  logic [1:0]          r_state;
  logic [MAP_BITS-1:0] r_work;
  logic [3:0]          r_y;
  logic [4:0]          r_k;
  logic [MAP_BITS-1:0] r_map_out;
  logic [4:0]          r_lines;
  logic [9:0]          r_total;
  logic                r_top;

  logic [MAP_BITS-1:0] w_collapsed;
  logic [MAP_W-1:0]    w_row;
  logic                w_full;
  logic [10:0]         w_sum;
  logic [9:0]          w_total_sat;

  row_collapse u_collapse (
    .i_map (r_work),
    .i_y   (r_y),
    .o_map (w_collapsed)
  );

  assign w_row       = r_work[row_base(r_y) +: MAP_W];
  assign w_full      = &w_row;
  // Sum is one bit wider than the total so a large k can never wrap below the limit.
  assign w_sum       = 11'(r_total) + 11'(r_k);
  assign w_total_sat = (w_sum > 11'(MAXL)) ? 10'(MAXL) : w_sum[9:0];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_work    <= '0;
      r_y       <= '0;
      r_k       <= '0;
      r_map_out <= '0;
      r_lines   <= '0;
      r_total   <= '0;
      r_top     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_work  <= bus.map_in;
          r_y     <= 4'(MAP_H - 1);
          r_k     <= '0;
          r_state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (w_full) begin
            // y holds so the row that just dropped into place is examined next.
            r_work <= w_collapsed;
            r_k    <= r_k + 5'd1;
          end else if (r_y != 4'd0) begin
            r_y <= r_y - 4'd1;
          end else begin
            r_map_out <= r_work;
            r_lines   <= r_k;
            r_top     <= |r_work[MAP_W-1:0];
            r_total   <= w_total_sat;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.done          = (r_state == ST_DONE);
  assign bus.map_out       = r_map_out;
  assign bus.lines_cleared = r_lines;
  assign bus.lines_total   = r_total;
  assign bus.top_out       = r_top;
endmodule

// File: tb/tb_line_clear.sv
// Directed vectors for line_clear: latency, collapse results, saturation, top-out, re-start and reset abort.
module tb_line_clear;
  import tetris_pkg::*;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  line_clear_if bus ();

  line_clear dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for edge E, then watch for done; returns with the DUT back in IDLE.
  task automatic run(input string tag, input logic [127:0] m, input int k_exp,
                     input logic [127:0] exp_map, input int tot_exp, input bit top_exp,
                     input int repulse_at);
    int lat;
    int extra;
    lat = 0;
    @(negedge CLK);
    bus.map_in = m;
    bus.start  = 1'b1;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, 128'(bus.busy), 128'd1);
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK);
      #1;
      if (n == repulse_at) begin
        bus.start  = 1'b1;
        bus.map_in = ~m;
      end else begin
        bus.start  = 1'b0;
        bus.map_in = m;
      end
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_lat"},   128'(lat), 128'(16 + k_exp));
    chk({tag, "_map"},   bus.map_out, exp_map);
    chk({tag, "_lines"}, 128'(bus.lines_cleared), 128'(k_exp));
    chk({tag, "_total"}, 128'(bus.lines_total), 128'(tot_exp));
    chk({tag, "_top"},   128'(bus.top_out), 128'(top_exp));
    @(posedge CLK);
    #1;
    chk({tag, "_idle"},  128'(bus.busy), 128'd0);
    if (repulse_at > 0) begin
      extra = 0;
      for (int n = 0; n < 30; n++) begin
        @(posedge CLK);
        #1;
        if (bus.done) extra++;
      end
      chk({tag, "_nodbl"}, 128'(extra), 128'd0);
    end
  endtask

  logic [127:0] m_empty, m_r15, m_r15_exp, m_four, m_four_exp, m_full, m_twelve, m_top, m_one;

  initial begin
    int ndone;
    bus.start  = 1'b0;
    bus.map_in = '0;
    m_empty    = '0;
    m_r15      = {8'hFF, 8'h81, 112'd0};
    m_r15_exp  = {8'h81, 120'd0};
    m_four     = {32'hFFFF_FFFF, 8'h3C, 88'd0};
    m_four_exp = {8'h3C, 120'd0};
    m_full     = '1;
    m_twelve   = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'd0};
    m_top      = {8'hFE, 112'd0, 8'h10};
    m_one      = {8'hFF, 120'd0};

    #12;
    chk("rst_busy",  128'(bus.busy), 128'd0);
    chk("rst_done",  128'(bus.done), 128'd0);
    chk("rst_map",   bus.map_out, 128'd0);
    chk("rst_total", 128'(bus.lines_total), 128'd0);
    chk("rst_top",   128'(bus.top_out), 128'd0);
    @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(posedge CLK);

    run("empty", m_empty, 0, 128'd0, 0, 1'b0, 0);
    run("r15",   m_r15, 1, m_r15_exp, 1, 1'b0, 0);
    run("four",  m_four, 4, m_four_exp, 5, 1'b0, 0);
    run("topout", m_top, 0, m_top, 5, 1'b1, 0);
    run("full1", m_full, 16, 128'd0, 21, 1'b0, 0);
    run("full2", m_full, 16, 128'd0, 37, 1'b0, 0);
    run("full3", m_full, 16, 128'd0, 53, 1'b0, 0);
    run("full4", m_full, 16, 128'd0, 69, 1'b0, 0);
    run("full5", m_full, 16, 128'd0, 85, 1'b0, 0);
    run("twelve", m_twelve, 12, 128'd0, 97, 1'b0, 0);
    run("sat4",  m_four, 4, m_four_exp, 99, 1'b0, 0);
    run("sat1",  m_one, 1, 128'd0, 99, 1'b0, 0);
    run("repulse", m_r15, 1, m_r15_exp, 99, 1'b0, 5);

    // Abort mid-scan: outputs must clear immediately and no done may follow.
    @(negedge CLK);
    bus.map_in = m_r15;
    bus.start  = 1'b1;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy",  128'(bus.busy), 128'd0);
    chk("abort_map",   bus.map_out, 128'd0);
    chk("abort_total", 128'(bus.lines_total), 128'd0);
    chk("abort_lines", 128'(bus.lines_cleared), 128'd0);
    @(negedge CLK);
    reset = 1'b1;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge CLK);
      #1;
      if (bus.done) ndone++;
    end
    chk("abort_nodone", 128'(ndone), 128'd0);

    run("after_rst", m_r15, 1, m_r15_exp, 1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
